// File: rtl/spi_target_frame_if.sv
// Bus bundle for spi_target_frame: SPI pins plus the parallel frame-side view.
// The slave modport is the target's side; the master modport is the driver's side.
interface spi_target_frame_if #(
  parameter int MAX_BYTES = 4,
  parameter int CW        = $clog2(MAX_BYTES + 1)
);
  logic                   spi_sclk;
  logic                   spi_cs_n;
  logic                   spi_rx;
  logic                   spi_tx;
  logic [8*MAX_BYTES-1:0] rx_data;
  logic [8*MAX_BYTES-1:0] tx_data;
  logic [CW-1:0]          length;
  logic [CW-1:0]          count;
  logic                   byte_strobe;
  logic                   frame_done;
  logic                   valid;
  logic                   overflow;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_rx, tx_data, length,
    output spi_tx, rx_data, count, byte_strobe, frame_done, valid, overflow
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_rx, tx_data, length,
    input  spi_tx, rx_data, count, byte_strobe, frame_done, valid, overflow
  );
endinterface

// File: rtl/spi_target_frame.sv
// Oversampled SPI target: receives up to MAX_BYTES bytes per CS_N frame into a flat
// array while shifting tx_data out on MISO, entirely in the clk domain.
module spi_target_frame #(
  parameter int MAX_BYTES = 4,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter int CW        = $clog2(MAX_BYTES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  spi_target_frame_if.slave bus
);
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;
  state_t state, state_next;

  logic sclk_p0, sclk_p1, sclk_p2;
  logic cs_p0, cs_p1, cs_p2;
  logic rx_p0, rx_p1;

  // p0/p1: two-flop synchronisers; p2: previous synchronised value for edge detection
  always_ff @(posedge clk) begin
    sclk_p0 <= bus.spi_sclk;
    sclk_p1 <= sclk_p0;
    sclk_p2 <= sclk_p1;
    cs_p0   <= bus.spi_cs_n;
    cs_p1   <= cs_p0;
    cs_p2   <= cs_p1;
    rx_p0   <= bus.spi_rx;
    rx_p1   <= rx_p0;
  end

  logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;
  assign lead_edge   = (sclk_p2 == CPOL) && (sclk_p1 != CPOL);
  assign trail_edge  = (sclk_p2 != CPOL) && (sclk_p1 == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = cs_p2 & ~cs_p1;
  assign cs_rise     = ~cs_p2 & cs_p1;

  function automatic logic [7:0] tx_byte_at(input logic [CW-1:0] idx,
                                            input logic [8*MAX_BYTES-1:0] data);
    tx_byte_at = 8'h00;
    for (int i = 0; i < MAX_BYTES; i++)
      if (idx == CW'(i)) tx_byte_at = data[8*i +: 8];
  endfunction

  logic frame_start, frame_end, do_sample, do_shift;

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    do_sample   = 1'b0;
    do_shift    = 1'b0;
    unique case (state)
      // Require CS_N high in both synchronised copies so no stale fall is pending
      WAIT_IDLE: if (cs_p1 && cs_p2) state_next = IDLE;
      IDLE: begin
        if (cs_fall) begin
          state_next  = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end else begin
          do_sample = sample_edge;
          do_shift  = shift_edge;
        end
      end
      default: state_next = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_IDLE;
    else       state <= state_next;
  end

  logic [2:0] bit_cnt;
  logic [3:0] tx_bit;
  logic [7:0] rx_sr, tx_sr, rx_byte, tx_next;

  assign rx_byte   = {rx_sr[6:0], rx_p1};
  assign tx_next   = tx_byte_at(bus.count, bus.tx_data);
  assign bus.valid = (bus.count == bus.length);

  // tx_bit counts bits already driven in the current byte; 0 means byte 0 not yet started
  always_ff @(posedge clk) begin
    bus.byte_strobe <= 1'b0;
    bus.frame_done  <= 1'b0;
    if (reset) begin
      bus.count    <= '0;
      bus.rx_data  <= '0;
      bus.overflow <= 1'b0;
      bus.spi_tx   <= 1'b0;
      bit_cnt      <= 3'd0;
      tx_bit       <= 4'd0;
      rx_sr        <= 8'h00;
      tx_sr        <= 8'h00;
    end else if (frame_start) begin
      bus.count    <= '0;
      bus.overflow <= 1'b0;
      bit_cnt      <= 3'd0;
      rx_sr        <= 8'h00;
      tx_sr        <= bus.tx_data[7:0];
      tx_bit       <= CPHA ? 4'd0 : 4'd1;
      bus.spi_tx   <= CPHA ? 1'b0 : bus.tx_data[7];
    end else if (frame_end) begin
      bus.frame_done <= 1'b1;
      bus.spi_tx     <= 1'b0;
      bit_cnt        <= 3'd0;
    end else begin
      if (do_sample) begin
        rx_sr   <= rx_byte;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (bus.count < CW'(MAX_BYTES)) begin
            for (int i = 0; i < MAX_BYTES; i++)
              if (bus.count == CW'(i)) bus.rx_data[8*i +: 8] <= rx_byte;
            bus.byte_strobe <= 1'b1;
            bus.count       <= bus.count + 1'b1;
          end else begin
            bus.overflow <= 1'b1;
          end
        end
      end
      if (do_shift) begin
        if (tx_bit == 4'd8) begin
          tx_sr      <= tx_next;
          bus.spi_tx <= tx_next[7];
          tx_bit     <= 4'd1;
        end else if (tx_bit == 4'd0) begin
          bus.spi_tx <= tx_sr[7];
          tx_bit     <= 4'd1;
        end else begin
          bus.spi_tx <= tx_sr[6];
          tx_sr      <= {tx_sr[6:0], 1'b0};
          tx_bit     <= tx_bit + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_target_frame.sv
// Randomised bench for spi_target_frame: four SPI modes with MAX_BYTES=4 plus a
// MAX_BYTES=2 mode-0 instance, each frame checked against a byte-level reference model.
module tb_spi_target_frame;
  localparam int NI = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0]        sclk, cs_n, mosi, miso, strb, done, ovf, vld;
  logic [NI-1:0][31:0]  txd, rxd;
  logic [NI-1:0][2:0]   len, cnt;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_target_frame_if #(.MAX_BYTES(4)) bus ();
    spi_target_frame #(.MAX_BYTES(4), .CPOL(g >= 2), .CPHA(g % 2 == 1)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave));
    assign bus.spi_sclk = sclk[g];
    assign bus.spi_cs_n = cs_n[g];
    assign bus.spi_rx   = mosi[g];
    assign bus.tx_data  = txd[g];
    assign bus.length   = len[g];
    assign miso[g]      = bus.spi_tx;
    assign rxd[g]       = bus.rx_data;
    assign cnt[g]       = bus.count;
    assign strb[g]      = bus.byte_strobe;
    assign done[g]      = bus.frame_done;
    assign ovf[g]       = bus.overflow;
    assign vld[g]       = bus.valid;
  end

  spi_target_frame_if #(.MAX_BYTES(2)) bus2 ();
  spi_target_frame #(.MAX_BYTES(2), .CPOL(1'b0), .CPHA(1'b0)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave));
  assign bus2.spi_sclk = sclk[4];
  assign bus2.spi_cs_n = cs_n[4];
  assign bus2.spi_rx   = mosi[4];
  assign bus2.tx_data  = txd[4][15:0];
  assign bus2.length   = len[4][1:0];
  assign miso[4]       = bus2.spi_tx;
  assign rxd[4]        = {16'h0000, bus2.rx_data};
  assign cnt[4]        = {1'b0, bus2.count};
  assign strb[4]       = bus2.byte_strobe;
  assign done[4]       = bus2.frame_done;
  assign ovf[4]        = bus2.overflow;
  assign vld[4]        = bus2.valid;

  int strb_cnt [NI];
  int done_cnt [NI];
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (strb[i]) strb_cnt[i]++;
      if (done[i]) done_cnt[i]++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: per-instance received bytes and count, plus the current frame's MOSI bytes
  logic [7:0] rx_m [NI][4];
  int         cnt_m [NI];
  logic [7:0] mo [8];
  logic       miso_bits [64];

  function automatic logic bit_of(input int i);
    return mo[i / 8][7 - (i % 8)];
  endfunction

  task automatic run_frame(input int g, input int nbits, input int rst_bit, input string tag);
    int ph, s0, d0, nfull, mb, exp_n;
    logic cp, ch;
    logic [31:0] rx_exp, mg, me;
    mb = (g == 4) ? 2 : 4;
    cp = (g == 2 || g == 3);
    ch = (g == 1 || g == 3);
    s0 = strb_cnt[g];
    d0 = done_cnt[g];
    for (int i = 0; i < 64; i++) miso_bits[i] = 1'b0;
    do ph = $urandom_range(1, 9); while (ph == 5);
    @(posedge clk);
    #(ph);
    if (!ch && nbits > 0) mosi[g] = bit_of(0);
    cs_n[g] = 1'b0;
    #40;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        reset = 1'b1;
        #30;
        check({tag, ".rst_rx"}, rxd[g], 32'h0);
        check({tag, ".rst_cnt"}, 32'(cnt[g]), 32'h0);
        check({tag, ".rst_flags"}, {28'h0, ovf[g], miso[g], strb[g], done[g]}, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < NI; k++) begin
          cnt_m[k] = 0;
          for (int b = 0; b < 4; b++) rx_m[k][b] = 8'h00;
        end
        s0 = strb_cnt[g];
        d0 = done_cnt[g];
      end
      if (ch && i > 0) miso_bits[i-1] = miso[g];
      if (ch) mosi[g] = bit_of(i);
      sclk[g] = ~cp;
      #20;
      if (!ch) begin
        miso_bits[i] = miso[g];
        if (i + 1 < nbits) mosi[g] = bit_of(i + 1);
      end
      sclk[g] = cp;
      #20;
    end
    if (ch && nbits > 0) miso_bits[nbits-1] = miso[g];
    cs_n[g] = 1'b1;
    #100;
    @(negedge clk);

    nfull = (rst_bit >= 0) ? 0 : nbits / 8;
    if (rst_bit < 0) begin
      for (int k = 0; k < nfull && k < mb; k++) rx_m[g][k] = mo[k];
      cnt_m[g] = (nfull < mb) ? nfull : mb;
    end
    exp_n  = (nfull < mb) ? nfull : mb;
    rx_exp = 32'h0;
    for (int k = 0; k < mb; k++) rx_exp[8*k +: 8] = rx_m[g][k];
    check({tag, ".rx_data"}, rxd[g], rx_exp);
    check({tag, ".count"}, 32'(cnt[g]), 32'(cnt_m[g]));
    check({tag, ".overflow"}, 32'(ovf[g]), 32'(nfull > mb));
    check({tag, ".valid"}, 32'(vld[g]), 32'(cnt_m[g] == int'(len[g])));
    check({tag, ".strobes"}, 32'(strb_cnt[g] - s0), 32'(exp_n));
    check({tag, ".frame_done"}, 32'(done_cnt[g] - d0), (rst_bit >= 0) ? 32'd0 : 32'd1);
    if (nfull > 0) begin
      mg = 32'h0;
      me = 32'h0;
      for (int k = 0; k < nfull && k < 4; k++) begin
        for (int b = 0; b < 8; b++) mg[8*k + 7 - b] = miso_bits[8*k + b];
        me[8*k +: 8] = (k < mb) ? txd[g][8*k +: 8] : 8'h00;
      end
      check({tag, ".miso"}, mg, me);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cs_n = '1;
    mosi = '0;
    sclk = 5'b01100;
    txd  = '0;
    for (int i = 0; i < NI; i++) begin
      len[i]   = 3'd1;
      cnt_m[i] = 0;
      for (int b = 0; b < 4; b++) rx_m[i][b] = 8'h00;
    end
    for (int i = 0; i < 8; i++) mo[i] = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset%0d.rx", i), rxd[i], 32'h0);
      check($sformatf("reset%0d.state", i),
            {25'h0, cnt[i], ovf[i], miso[i], strb[i], done[i]}, 32'h0);
    end
    reset = 1'b0;
    repeat (5) @(posedge clk);

    // Mode 0, length 3
    len[0] = 3'd3;
    txd[0] = 32'h44332211;
    mo[0] = 8'hA5; mo[1] = 8'h3C; mo[2] = 8'hFF;
    run_frame(0, 24, -1, "t1");

    // All four modes, two-byte frame
    for (int g = 0; g < 4; g++) begin
      len[g] = 3'd2;
      txd[g] = 32'h00005AC3;
      mo[0] = 8'h81; mo[1] = 8'h7E;
      run_frame(g, 16, -1, $sformatf("t2m%0d", g));
    end

    // Overflow on the two-byte instance, then an empty frame clears status
    len[4] = 3'd2;
    txd[4] = 32'h0000BBAA;
    mo[0] = 8'h01; mo[1] = 8'h02; mo[2] = 8'h03;
    run_frame(4, 24, -1, "t3");
    run_frame(4, 0, -1, "t3next");

    // Partial trailing byte, then a clean frame
    len[0] = 3'd1;
    mo[0] = 8'h96; mo[1] = 8'hF8;
    run_frame(0, 13, -1, "t4");
    mo[0] = 8'h3A;
    run_frame(0, 8, -1, "t4next");

    // Reset mid-frame after 12 bits, then a full 0x55 frame
    mo[0] = 8'hC7; mo[1] = 8'h12;
    run_frame(0, 16, 12, "t5");
    mo[0] = 8'h55;
    run_frame(0, 8, -1, "t5next");

    // Random 4-byte frames across the four modes
    for (int it = 0; it < 200; it++) begin
      int g;
      g = $urandom_range(0, 3);
      len[g] = 3'($urandom_range(0, 4));
      txd[g] = $urandom;
      for (int k = 0; k < 4; k++) mo[k] = 8'($urandom);
      run_frame(g, 32, -1, $sformatf("t6i%0dm%0d", it, g));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
